// File: rtl/instr_decode_seq_pkg.sv
// Shared definitions for the instruction decode sequencer.
// Holds the opcode and op-field constants and the sequencer state encoding.
package instr_decode_seq_pkg;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_RN = 3'd1,
    RD_RM = 3'd2,
    WR_RD = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sign_ext.sv
// Sign extender: replicates the top bit of in_i up to OUT_W bits.
// Ports:
//   in_i  [IN_W-1:0]   value to extend
//   out_o [OUT_W-1:0]  sign-extended result (OUT_W must exceed IN_W)
module sign_ext #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  assign out_o = {{(OUT_W - IN_W){in_i[IN_W-1]}}, in_i};

endmodule

// File: rtl/instr_decode_seq.sv
// Instruction decode sequencer. Latches one 16-bit instruction, then walks a
// Moore FSM that issues register-file read/write strobes for ALU, CMP,
// MOV-reg and MOV-imm instructions. Unsupported opcodes are dropped with a
// one-cycle illegal pulse.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr, in_valid, in_ready  instruction handshake
//   stall                      freezes the sequencer (when STALL_EN != 0)
//   opcode, op, shift          fields of the latched instruction
//   sximm5, sximm8             sign-extended immediates (DATA_W bits)
//   rnum, rd_en                register-file read address / strobe
//   wnum, wr_en, wsel          register-file write address / strobe / source
//   done, illegal              completion and dropped-instruction pulses
module instr_decode_seq
  import instr_decode_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int STALL_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [2:0]        rnum,
  output logic [2:0]        wnum,
  output logic              rd_en,
  output logic              wr_en,
  output logic              wsel,
  output logic              done,
  output logic              illegal
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic        stall_eff;
  logic        accept;
  logic        ir_is_mov_imm;
  logic        ir_is_cmp;

  assign stall_eff = (STALL_EN != 0) && stall;

  // The illegal-pulse cycle also blocks acceptance, so a dropped instruction
  // costs two cycles before the next one can be taken.
  assign in_ready = rst_n && (state_q == IDLE) && !illegal_q && !stall_eff;
  assign accept   = in_valid && in_ready;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign shift  = ir_q[4:3];

  assign ir_is_mov_imm = (ir_q[15:13] == OPC_MOV) && (ir_q[12:11] == OP_MOV_IMM);
  assign ir_is_cmp     = (ir_q[15:13] == OPC_ALU) && (ir_q[12:11] == OP_CMP);

  sign_ext #(.IN_W(5), .OUT_W(DATA_W)) u_sx5 (
    .in_i  (ir_q[4:0]),
    .out_o (sximm5)
  );

  sign_ext #(.IN_W(8), .OUT_W(DATA_W)) u_sx8 (
    .in_i  (ir_q[7:0]),
    .out_o (sximm8)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic. The dispatch from IDLE looks at the incoming word
  // because IR is loaded on the same edge; everything later uses IR.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = 1'b0;
    if (!stall_eff) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ir_d = instr;
            if (instr[15:13] == OPC_ALU)
              state_d = RD_RN;
            else if (instr[15:13] == OPC_MOV && instr[12:11] == OP_MOV_REG)
              state_d = RD_RM;
            else if (instr[15:13] == OPC_MOV && instr[12:11] == OP_MOV_IMM)
              state_d = WR_RD;
            else
              illegal_d = 1'b1;
          end
        end
        RD_RN:   state_d = RD_RM;
        RD_RM:   state_d = ir_is_cmp ? DONE : WR_RD;
        WR_RD:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore output decode. Strobes are masked during a stall so that the held
  // state re-issues them once the stall clears.
  always_comb begin
    rnum    = 3'd0;
    wnum    = 3'd0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wsel    = 1'b0;
    done    = 1'b0;
    illegal = illegal_q;
    case (state_q)
      RD_RN: begin
        rnum  = ir_q[10:8];
        rd_en = !stall_eff;
      end
      RD_RM: begin
        rnum  = ir_q[2:0];
        rd_en = !stall_eff;
      end
      WR_RD: begin
        wnum  = ir_is_mov_imm ? ir_q[10:8] : ir_q[7:5];
        wsel  = ir_is_mov_imm;
        wr_en = !stall_eff;
      end
      DONE:    done = !stall_eff;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_decode_seq.sv
// Scoreboard bench for instr_decode_seq. Directed instructions push their
// expected strobe events into a queue; a monitor pops and compares one entry
// each cycle the DUT shows any strobe, done or illegal.
module tb_instr_decode_seq;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       ws;
    logic [2:0] rn;
    logic [2:0] wn;
    logic       dn;
    logic       il;
  } ev_t;

  logic              clk;
  logic              rst_n;
  logic [15:0]       instr;
  logic              in_valid;
  logic              in_ready;
  logic              stall;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [1:0]        shift;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] sximm8;
  logic [2:0]        rnum;
  logic [2:0]        wnum;
  logic              rd_en;
  logic              wr_en;
  logic              wsel;
  logic              done;
  logic              illegal;

  int  passCnt  = 0;
  int  totalCnt = 0;
  int  cyc      = 0;
  int  accCyc   = 0;
  ev_t expQ[$];

  instr_decode_seq #(.DATA_W(DATA_W), .STALL_EN(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .stall    (stall),
    .opcode   (opcode),
    .op       (op),
    .shift    (shift),
    .sximm5   (sximm5),
    .sximm8   (sximm8),
    .rnum     (rnum),
    .wnum     (wnum),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wsel     (wsel),
    .done     (done),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t rdEv(input logic [2:0] r);
    return '{rd: 1'b1, wr: 1'b0, ws: 1'b0, rn: r, wn: 3'd0, dn: 1'b0, il: 1'b0};
  endfunction

  function automatic ev_t wrEv(input logic [2:0] w, input logic s);
    return '{rd: 1'b0, wr: 1'b1, ws: s, rn: 3'd0, wn: w, dn: 1'b0, il: 1'b0};
  endfunction

  function automatic ev_t doneEv();
    return '{rd: 1'b0, wr: 1'b0, ws: 1'b0, rn: 3'd0, wn: 3'd0, dn: 1'b1, il: 1'b0};
  endfunction

  function automatic ev_t illEv();
    return '{rd: 1'b0, wr: 1'b0, ws: 1'b0, rn: 3'd0, wn: 3'd0, dn: 1'b0, il: 1'b1};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every cycle with visible activity must match the next queued event.
  always @(negedge clk) begin
    ev_t obs;
    obs = {rd_en, wr_en, wsel, rnum, wnum, done, illegal};
    if (rd_en || wr_en || done || illegal) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_event", 64'(obs), 64'h0);
      end else begin
        checkOutput("event", 64'(obs), 64'(expQ.pop_front()));
      end
    end
  end

  // Wait for in_ready, present one instruction and return just after the
  // accepting edge with accCyc recording that edge.
  task automatic applyStimulus(input logic [15:0] ins);
    bit ready = 0;
    for (int i = 0; i < 20 && !ready; i++) begin
      @(negedge clk);
      if (in_ready) ready = 1;
    end
    if (!ready) checkOutput("ready_timeout", 64'd0, 64'd1);
    instr    = ins;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    accCyc   = cyc;
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, input int expLat);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (seen) checkOutput(name, 64'(cyc - accCyc), 64'(expLat));
    else checkOutput({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    instr    = 16'h0000;
    in_valid = 1'b0;
    stall    = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_strobes", 64'({rd_en, wr_en, wsel, done, illegal}), 64'd0);
    checkOutput("rst_fields", 64'({rnum, wnum, opcode, op, shift}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    // ALU ADD r5 = r1 + r3, with a competing in_valid held while busy
    expQ.push_back(rdEv(3'd1));
    expQ.push_back(rdEv(3'd3));
    expQ.push_back(wrEv(3'd5, 1'b0));
    expQ.push_back(doneEv());
    applyStimulus(16'hA1A3);
    checkOutput("alu_fields", 64'({opcode, op, shift}), 64'({3'b101, 2'b00, 2'b00}));
    instr    = 16'h0000;
    in_valid = 1'b1;
    waitDone("alu_latency", 3);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("alu_ready_back", 64'(in_ready), 64'd1);

    // MOV imm r2 = sximm8(0xFB)
    expQ.push_back(wrEv(3'd2, 1'b1));
    expQ.push_back(doneEv());
    applyStimulus(16'hD2FB);
    checkOutput("movimm_sximm8", 64'(sximm8), 64'hFFFF_FFFB);
    checkOutput("movimm_sximm5", 64'(sximm5), 64'hFFFF_FFFB);
    waitDone("movimm_latency", 1);

    // CMP r1, r2: reads only, no write
    expQ.push_back(rdEv(3'd1));
    expQ.push_back(rdEv(3'd2));
    expQ.push_back(doneEv());
    applyStimulus(16'hA9A2);
    waitDone("cmp_latency", 2);

    // MOV reg r7 = r4, positive sximm5
    expQ.push_back(rdEv(3'd4));
    expQ.push_back(wrEv(3'd7, 1'b0));
    expQ.push_back(doneEv());
    applyStimulus(16'hC0E4);
    checkOutput("movreg_sximm5", 64'(sximm5), 64'd4);
    waitDone("movreg_latency", 2);

    // Illegal opcode: single pulse, ready again two cycles after accept
    expQ.push_back(illEv());
    applyStimulus(16'h0000);
    @(negedge clk);
    checkOutput("ill_ready_blocked", 64'(in_ready), 64'd0);
    @(negedge clk);
    checkOutput("ill_ready_back", 64'(in_ready), 64'd1);

    // ALU with a 3-cycle stall while in RD_RM
    expQ.push_back(rdEv(3'd1));
    expQ.push_back(rdEv(3'd3));
    expQ.push_back(wrEv(3'd5, 1'b0));
    expQ.push_back(doneEv());
    applyStimulus(16'hA1A3);
    @(posedge clk);
    #1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_rd_en", 64'(rd_en), 64'd0);
      checkOutput("stall_rnum_held", 64'(rnum), 64'd3);
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    waitDone("stall_latency", 6);

    // Reset pulsed while in WR_RD: no done, ready after release
    expQ.push_back(rdEv(3'd1));
    expQ.push_back(rdEv(3'd3));
    expQ.push_back(wrEv(3'd5, 1'b0));
    applyStimulus(16'hA1A3);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_ready_back", 64'(in_ready), 64'd1);
    checkOutput("midrst_ir_cleared", 64'({opcode, op, shift}), 64'd0);
    repeat (4) @(negedge clk);

    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
